lagarto_plic_target_controller: RTL and testbench

LAGARTO_PLIC_TARGET_CONTROLLER -- requirements
Module: lagarto_plic_target_controller

---
 rtl/lagarto_plic_target_controller.sv | 173 +++++++++++++++++
 tb/tb_lagarto_plic_target_controller.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lagarto_plic_target_controller.sv
// -----------------------------------------------------------------------------
// lagarto_plic_target_controller
//
// Per-target (per-hart context) PLIC controller. It watches the winner at the
// end of the priority multiplexer chain. When that winner beats the target
// threshold, it raises the external interrupt notification. It then runs the
// claim/complete handshake with the hart.
//
// Ports
//   clk_i                    clock, rising edge
//   rst_i                    asynchronous active-high reset
//   maximum_priority_i       winning priority from the mux chain
//   maximum_id_i             winning source ID from the mux chain (0 = none)
//   priority_threshold_i     target threshold; the winner must be strictly above
//   interrupt_claim_i        one-cycle claim strobe from the hart
//   interrupt_complete_i     one-cycle completion strobe from the hart
//   complete_id_i            ID being completed, sampled with the strobe
//   interrupt_notification_o external interrupt pending (EIP) to the hart
//   interrupt_id_o           claim response ID, zero-extended to MXLEN
//   claim_pulse_o            one-hot pulse clearing the claimed pending bit
//   complete_pulse_o         one-hot pulse releasing the completed gateway
//   claim_busy_o             high while a claimed interrupt is outstanding
//   state_o                  FSM state for observation (0 IDLE, 1 PENDING,
//                            2 CLAIMED)
//
// Strobe semantics: claim and complete are single-cycle strobes. They are
// acted on in the cycle they are high, and there is no back-pressure. Every
// response (ID, pulses, notification, busy) is registered and appears in the
// cycle after the strobe. claim_pulse_o and complete_pulse_o are each zero or
// one-hot. They are never nonzero in the same cycle, because a claim is only
// honoured in PENDING and a completion is only honoured in CLAIMED.
// -----------------------------------------------------------------------------
module lagarto_plic_target_controller #(
  parameter int NUMBER_OF_INTERRUPT_SOURCES = 32,
  parameter int PRIORITY_WIDTH              = 3,
  parameter int ID_WIDTH                    = 6,
  parameter int MXLEN                       = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [PRIORITY_WIDTH-1:0]              maximum_priority_i,
  input  logic [ID_WIDTH-1:0]                    maximum_id_i,
  input  logic [PRIORITY_WIDTH-1:0]              priority_threshold_i,
  input  logic                                   interrupt_claim_i,
  input  logic                                   interrupt_complete_i,
  input  logic [ID_WIDTH-1:0]                    complete_id_i,
  output logic                                   interrupt_notification_o,
  output logic [MXLEN-1:0]                       interrupt_id_o,
  output logic [NUMBER_OF_INTERRUPT_SOURCES-1:0] claim_pulse_o,
  output logic [NUMBER_OF_INTERRUPT_SOURCES-1:0] complete_pulse_o,
  output logic                                   claim_busy_o,
  output logic [1:0]                             state_o
);

  localparam int N = NUMBER_OF_INTERRUPT_SOURCES;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_CLAIMED = 2'd2
  } state_t;

  state_t              state_q;
  logic                notif_q;
  logic [ID_WIDTH-1:0] resp_id_q;    // value returned to the hart on a claim
  logic [ID_WIDTH-1:0] claimed_id_q; // outstanding claim, compared on complete
  logic [N-1:0]        claim_pulse_q;
  logic [N-1:0]        complete_pulse_q;
  logic                busy_q;

  logic                cand_valid;
  logic                complete_hit;
  logic [N-1:0]        claim_onehot;
  logic [N-1:0]        complete_onehot;

  // Source IDs are 1-based, so ID k maps to bit k-1. ID 0 and out-of-range IDs
  // give an all-zero vector.
  function automatic logic [N-1:0] id_to_onehot(input logic [ID_WIDTH-1:0] id);
    logic [N-1:0] oh;
    oh = '0;
    for (int i = 0; i < N; i++) begin
      oh[i] = (id == ID_WIDTH'(i + 1));
    end
    return oh;
  endfunction

  // Strict compare: a winner equal to the threshold does not interrupt. With an
  // unsigned compare, priority 0 can never qualify.
  assign cand_valid = (maximum_priority_i > priority_threshold_i) &&
                      (maximum_id_i != '0) &&
                      (maximum_id_i <= ID_WIDTH'(N));

  assign complete_hit    = interrupt_complete_i && (complete_id_i == claimed_id_q);
  assign claim_onehot    = id_to_onehot(maximum_id_i);
  assign complete_onehot = id_to_onehot(claimed_id_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      notif_q          <= 1'b0;
      resp_id_q        <= '0;
      claimed_id_q     <= '0;
      claim_pulse_q    <= '0;
      complete_pulse_q <= '0;
      busy_q           <= 1'b0;
    end else begin
      // Pulses last exactly one cycle unless re-armed below.
      claim_pulse_q    <= '0;
      complete_pulse_q <= '0;

      case (state_q)
        ST_IDLE: begin
          if (interrupt_claim_i) begin
            resp_id_q <= '0;
          end
          if (cand_valid) begin
            state_q <= ST_PENDING;
            notif_q <= 1'b1;
          end else begin
            notif_q <= 1'b0;
          end
        end

        ST_PENDING: begin
          if (interrupt_claim_i && cand_valid) begin
            // The claim takes the winner as it stands in the claim cycle.
            resp_id_q     <= maximum_id_i;
            claimed_id_q  <= maximum_id_i;
            claim_pulse_q <= claim_onehot;
            state_q       <= ST_CLAIMED;
            notif_q       <= 1'b0;
            busy_q        <= 1'b1;
          end else if (!cand_valid) begin
            // The winner has dropped away. A claim in this cycle is spurious.
            if (interrupt_claim_i) begin
              resp_id_q <= '0;
            end
            state_q <= ST_IDLE;
            notif_q <= 1'b0;
          end
        end

        ST_CLAIMED: begin
          // Only one claim may be outstanding, so any claim here reads 0.
          if (interrupt_claim_i) begin
            resp_id_q <= '0;
          end
          if (complete_hit) begin
            complete_pulse_q <= complete_onehot;
            claimed_id_q     <= '0;
            state_q          <= ST_IDLE;
            busy_q           <= 1'b0;
            notif_q          <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          notif_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt_notification_o = notif_q;
  assign interrupt_id_o           = MXLEN'(resp_id_q);
  assign claim_pulse_o            = claim_pulse_q;
  assign complete_pulse_o         = complete_pulse_q;
  assign claim_busy_o             = busy_q;
  assign state_o                  = state_q;

endmodule

// File: tb/tb_lagarto_plic_target_controller.sv
// -----------------------------------------------------------------------------
// tb_lagarto_plic_target_controller
//
// Directed vectors for the PLIC target controller. Each table row gives the
// inputs held for one clock cycle and the outputs expected just after that
// edge. The expected values are worked out by hand from the intended
// behaviour. A hand-written sequence covers a reset asserted while a claim is
// outstanding.
// -----------------------------------------------------------------------------
module tb_lagarto_plic_target_controller;

  localparam int N  = 32;
  localparam int PW = 3;
  localparam int IW = 6;
  localparam int XL = 64;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_CLAIMED = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [PW-1:0] max_pri;
  logic [IW-1:0] max_id;
  logic [PW-1:0] thr;
  logic          claim;
  logic          complete;
  logic [IW-1:0] cid;

  logic          notif;
  logic [XL-1:0] id_o;
  logic [N-1:0]  cp;
  logic [N-1:0]  kp;
  logic          busy;
  logic [1:0]    st;

  lagarto_plic_target_controller #(
    .NUMBER_OF_INTERRUPT_SOURCES(N),
    .PRIORITY_WIDTH(PW),
    .ID_WIDTH(IW),
    .MXLEN(XL)
  ) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .maximum_priority_i      (max_pri),
    .maximum_id_i            (max_id),
    .priority_threshold_i    (thr),
    .interrupt_claim_i       (claim),
    .interrupt_complete_i    (complete),
    .complete_id_i           (cid),
    .interrupt_notification_o(notif),
    .interrupt_id_o          (id_o),
    .claim_pulse_o           (cp),
    .complete_pulse_o        (kp),
    .claim_busy_o            (busy),
    .state_o                 (st)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic [PW-1:0] pri;
    logic [IW-1:0] id;
    logic [PW-1:0] thr;
    logic          claim;
    logic          complete;
    logic [IW-1:0] cid;
    logic          e_notif;
    logic [XL-1:0] e_id;
    logic [N-1:0]  e_cp;
    logic [N-1:0]  e_kp;
    logic          e_busy;
    logic [1:0]    e_st;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  int applied = 0;
  int miscompares = 0;

  function automatic vec_t mk(input int pri, input int id, input int th,
                              input bit cl, input bit co, input int ci,
                              input bit en, input int eid, input logic [N-1:0] ecp,
                              input logic [N-1:0] ekp, input bit eb, input logic [1:0] es);
    vec_t v;
    v.pri = PW'(pri); v.id = IW'(id); v.thr = PW'(th);
    v.claim = cl; v.complete = co; v.cid = IW'(ci);
    v.e_notif = en; v.e_id = XL'(eid); v.e_cp = ecp; v.e_kp = ekp;
    v.e_busy = eb; v.e_st = es;
    return v;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string name, input logic e_notif, input logic [XL-1:0] e_id,
                       input logic [N-1:0] e_cp, input logic [N-1:0] e_kp,
                       input logic e_busy, input logic [1:0] e_st);
    applied++;
    if (notif !== e_notif || id_o !== e_id || cp !== e_cp || kp !== e_kp ||
        busy !== e_busy || st !== e_st) begin
      miscompares++;
      $display("FAIL %s: got notif=%b id=%0h cp=%h kp=%h busy=%b st=%0d, want notif=%b id=%0h cp=%h kp=%h busy=%b st=%0d",
               name, notif, id_o, cp, kp, busy, st, e_notif, e_id, e_cp, e_kp, e_busy, e_st);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [PW-1:0] p, input logic [IW-1:0] i, input logic [PW-1:0] t,
                       input logic cl, input logic co, input logic [IW-1:0] c);
    max_pri = p; max_id = i; thr = t; claim = cl; complete = co; cid = c;
  endtask

  task automatic apply(input int k);
    drive(vecs[k].pri, vecs[k].id, vecs[k].thr, vecs[k].claim, vecs[k].complete, vecs[k].cid);
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", k), vecs[k].e_notif, vecs[k].e_id, vecs[k].e_cp,
          vecs[k].e_kp, vecs[k].e_busy, vecs[k].e_st);
  endtask

  initial begin
    //                pri id thr cl co cid  notif id  cp          kp          busy state
    // basic flow
    vecs[0]  = mk(5, 3, 2, 0, 0, 0,   1, 0, 32'h0,  32'h0,  0, S_PENDING);
    vecs[1]  = mk(5, 3, 2, 1, 0, 0,   0, 3, 32'h4,  32'h0,  1, S_CLAIMED);
    vecs[2]  = mk(5, 3, 2, 0, 0, 0,   0, 3, 32'h0,  32'h0,  1, S_CLAIMED);
    vecs[3]  = mk(5, 3, 2, 0, 1, 3,   0, 3, 32'h0,  32'h4,  0, S_IDLE);
    vecs[4]  = mk(5, 3, 2, 0, 0, 0,   1, 3, 32'h0,  32'h0,  0, S_PENDING);
    // threshold boundary: equal does not qualify, one lower does
    vecs[5]  = mk(2, 3, 2, 0, 0, 0,   0, 3, 32'h0,  32'h0,  0, S_IDLE);
    vecs[6]  = mk(2, 3, 2, 0, 0, 0,   0, 3, 32'h0,  32'h0,  0, S_IDLE);
    vecs[7]  = mk(2, 3, 1, 0, 0, 0,   1, 3, 32'h0,  32'h0,  0, S_PENDING);
    // priority 0, spurious claim in IDLE, ID 0, out-of-range ID
    vecs[8]  = mk(0, 0, 0, 0, 0, 0,   0, 3, 32'h0,  32'h0,  0, S_IDLE);
    vecs[9]  = mk(0, 0, 0, 1, 0, 0,   0, 0, 32'h0,  32'h0,  0, S_IDLE);
    vecs[10] = mk(5, 0, 0, 0, 0, 0,   0, 0, 32'h0,  32'h0,  0, S_IDLE);
    vecs[11] = mk(5, 33,0, 0, 0, 0,   0, 0, 32'h0,  32'h0,  0, S_IDLE);
    // ID 7: second claim while CLAIMED, wrong then right completion
    vecs[12] = mk(7, 7, 0, 0, 0, 0,   1, 0, 32'h0,  32'h0,  0, S_PENDING);
    vecs[13] = mk(7, 7, 0, 1, 0, 0,   0, 7, 32'h40, 32'h0,  1, S_CLAIMED);
    vecs[14] = mk(7, 7, 0, 1, 0, 0,   0, 0, 32'h0,  32'h0,  1, S_CLAIMED);
    vecs[15] = mk(7, 7, 0, 0, 1, 6,   0, 0, 32'h0,  32'h0,  1, S_CLAIMED);
    vecs[16] = mk(7, 7, 0, 0, 1, 7,   0, 0, 32'h0,  32'h40, 0, S_IDLE);
    // claim in PENDING after the candidate has dropped away
    vecs[17] = mk(4, 1, 0, 0, 0, 0,   1, 0, 32'h0,  32'h0,  0, S_PENDING);
    vecs[18] = mk(0, 1, 0, 1, 0, 0,   0, 0, 32'h0,  32'h0,  0, S_IDLE);
    // claim+complete in PENDING: claim wins; then in CLAIMED: complete wins
    vecs[19] = mk(4, 1, 0, 0, 0, 0,   1, 0, 32'h0,  32'h0,  0, S_PENDING);
    vecs[20] = mk(4, 1, 0, 1, 1, 1,   0, 1, 32'h1,  32'h0,  1, S_CLAIMED);
    vecs[21] = mk(4, 1, 0, 1, 1, 1,   0, 0, 32'h0,  32'h1,  0, S_IDLE);
    // completion in IDLE is ignored
    vecs[22] = mk(4, 1, 0, 0, 1, 1,   1, 0, 32'h0,  32'h0,  0, S_PENDING);

    drive(0, 0, 0, 0, 0, 0);

    // reset state
    #1;
    check("reset_state", 0, 0, 0, 0, 0, S_IDLE);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < NV; k++) begin
      apply(k);
    end

    // reset asserted while ID 4 is claimed
    drive(6, 4, 1, 0, 0, 0);
    @(posedge clk); #1;
    check("rst_seq_pending", 1, 0, 32'h0, 32'h0, 0, S_PENDING);
    drive(6, 4, 1, 1, 0, 0);
    @(posedge clk); #1;
    check("rst_seq_claim4", 0, 4, 32'h8, 32'h0, 1, S_CLAIMED);
    drive(6, 4, 1, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_clear", 0, 0, 32'h0, 32'h0, 0, S_IDLE);
    drive(6, 4, 1, 0, 1, 4);
    @(posedge clk); #1;
    check("rst_held_no_kp", 0, 0, 32'h0, 32'h0, 0, S_IDLE);
    drive(6, 4, 1, 0, 0, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_release_reeval", 1, 0, 32'h0, 32'h0, 0, S_PENDING);
    // the old claim was discarded, so completing ID 4 is ignored
    drive(6, 4, 1, 0, 1, 4);
    @(posedge clk); #1;
    check("rst_stale_complete", 1, 0, 32'h0, 32'h0, 0, S_PENDING);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
